axil_slave_ctrl: RTL and testbench

AXIL_SLAVE_CTRL -- requirements
Module: axil_slave_ctrl

---
 rtl/axil_slave_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_axil_slave_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_ctrl.sv
// AXI4-Lite slave front end: independent write and read FSMs that share one
// single-cycle register port through a round-robin arbiter.
module axil_slave_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0]     s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  err_awrite_i,
    input  logic                  err_write_i,
    input  logic                  err_read_i,
    output logic                  reg_wr_o,
    output logic                  reg_rd_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic [STRB_W-1:0]     reg_wstrb_o,
    input  logic [DATA_WIDTH-1:0] reg_rdata_i
);

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_ACCESS = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_ACCESS = 2'd1;
    localparam logic [1:0] R_WAIT   = 2'd2;
    localparam logic [1:0] R_RESP   = 2'd3;

    logic [1:0]            w_state_q, w_state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  wr_err_q, wr_err_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic [1:0]            r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  last_wr_q, last_wr_d;
    logic                  wr_req, rd_req, wr_gnt, rd_gnt;
    logic                  aw_hs, w_hs, ar_hs;

    // Register-port arbiter; the last-grant flag only moves on contested
    // cycles, so back-to-back ties alternate regardless of lone grants between.
    always_comb begin
        wr_req    = (w_state_q == W_ACCESS) && !rst_i;
        rd_req    = (r_state_q == R_ACCESS) && !rst_i;
        wr_gnt    = wr_req && (!rd_req || !last_wr_q);
        rd_gnt    = rd_req && !wr_gnt;
        last_wr_d = last_wr_q;
        if (wr_req && rd_req) begin
            last_wr_d = wr_gnt;
        end
    end

    // Write FSM: capture AW/W in any order, strobe once, then respond.
    always_comb begin
        aw_hs     = s_axi_awvalid && awready_q;
        w_hs      = s_axi_wvalid && wready_q;
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_err_d  = wr_err_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    waddr_d   = s_axi_awaddr;
                    wr_err_d  = wr_err_d | err_awrite_i;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    wr_err_d = wr_err_d | err_write_i;
                end
                if (aw_done_d && w_done_d) begin
                    w_state_d = wr_err_d ? W_RESP : W_ACCESS;
                end
            end
            W_ACCESS: begin
                if (wr_gnt) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wr_err_d  = 1'b0;
                    waddr_d   = '0;
                    wdata_d   = '0;
                    wstrb_d   = '0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_done_d;
        wready_d  = (w_state_d == W_IDLE) && !w_done_d;
    end

    // Read FSM: accept AR, strobe, wait one cycle for data, then respond.
    always_comb begin
        ar_hs     = s_axi_arvalid && arready_q;
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    raddr_d = s_axi_araddr;
                    if (err_read_i) begin
                        rdata_d   = '0;
                        rresp_d   = 2'b10;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_ACCESS;
                    end
                end
            end
            R_ACCESS: begin
                if (rd_gnt) begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                rdata_d   = reg_rdata_i;
                rresp_d   = 2'b00;
                r_state_d = R_RESP;
            end
            default: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    raddr_d   = '0;
                    rdata_d   = '0;
                    rresp_d   = 2'b00;
                end
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            raddr_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            last_wr_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_err_q  <= wr_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Output decode; valids and strobes are masked while reset is asserted.
    always_comb begin
        s_axi_awready = awready_q;
        s_axi_wready  = wready_q;
        s_axi_arready = arready_q;
        s_axi_bvalid  = (w_state_q == W_RESP) && !rst_i;
        s_axi_bresp   = (s_axi_bvalid && wr_err_q) ? 2'b10 : 2'b00;
        s_axi_rvalid  = (r_state_q == R_RESP) && !rst_i;
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = rresp_q;
        reg_wr_o      = wr_gnt;
        reg_rd_o      = rd_gnt;
        reg_addr_o    = wr_gnt ? waddr_q : (rd_gnt ? raddr_q : '0);
        reg_wdata_o   = wr_gnt ? wdata_q : '0;
        reg_wstrb_o   = wr_gnt ? wstrb_q : '0;
    end

endmodule

// File: tb/tb_axil_slave_ctrl.sv
// Self-checking bench for axil_slave_ctrl: directed protocol scenarios plus a
// randomized transaction stream checked against a word-addressed memory model.
`timescale 1ns/1ps
module tb_axil_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        err_awrite_i = 1'b0;
    logic        err_write_i = 1'b0;
    logic        err_read_i = 1'b0;
    logic        reg_wr_o, reg_rd_o;
    logic [31:0] reg_addr_o, reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic [31:0] reg_rdata_i = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    axil_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .err_awrite_i(err_awrite_i), .err_write_i(err_write_i), .err_read_i(err_read_i),
        .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_rdata_i(reg_rdata_i)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    typedef struct packed {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_ev_t;

    wr_ev_t      wr_log[$];
    int          rd_cyc[$];
    logic [31:0] rd_addr_log[$];
    logic [31:0] resp_mem [16] = '{default: '0};
    logic [31:0] exp_mem [16] = '{default: '0};
    logic [3:0]  rsp_idx;

    // Register file on the far side of the port, plus bus-idle checks.
    always @(negedge clk) begin : port_monitor
        check("strobe_exclusive", reg_wr_o & reg_rd_o, 0);
        if (!reg_wr_o && !reg_rd_o) begin
            check("idle_addr", reg_addr_o, 0);
            check("idle_wdata", reg_wdata_o, 0);
            check("idle_wstrb", reg_wstrb_o, 0);
        end
        if (reg_wr_o) begin
            wr_log.push_back('{c: cyc, a: reg_addr_o, d: reg_wdata_o, s: reg_wstrb_o});
            for (int j = 0; j < 4; j++)
                if (reg_wstrb_o[j]) resp_mem[reg_addr_o[5:2]][j*8 +: 8] = reg_wdata_o[j*8 +: 8];
        end
        if (reg_rd_o) begin
            rd_cyc.push_back(cyc);
            rd_addr_log.push_back(reg_addr_o);
        end
    end

    // Read data appears only during the cycle after the strobe.
    always @(negedge clk) begin : rdata_responder
        if (reg_rd_o) begin
            rsp_idx = reg_addr_o[5:2];
            @(posedge clk);
            #1 reg_rdata_i = resp_mem[rsp_idx];
            @(posedge clk);
            #1 reg_rdata_i = $urandom;
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_bresp", s_axi_bresp, 0);
        check("rst_rresp", s_axi_rresp, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_reg_wr", reg_wr_o, 0);
        check("rst_reg_rd", reg_rd_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rel_awready", s_axi_awready, 1);
        check("rel_wready", s_axi_wready, 1);
        check("rel_arready", s_axi_arready, 1);
        @(posedge clk); #1;
    endtask

    // wl: cycles from capture to the expected write strobe (1 uncontended).
    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input bit ea, ew,
                            input int dly_aw, dly_w, dly_b, wl);
        bit aw_ok = 0, w_ok = 0, err;
        int k = 0, hs_c = -1, bcyc = -1, n_before;
        wr_ev_t ev;
        n_before = wr_log.size();
        err = ea || ew;
        while (!(aw_ok && w_ok) && k < 40) begin
            s_axi_awvalid = !aw_ok && (k >= dly_aw);
            s_axi_awaddr  = s_axi_awvalid ? a : $urandom;
            err_awrite_i  = s_axi_awvalid ? ea : 1'($urandom);
            s_axi_wvalid  = !w_ok && (k >= dly_w);
            s_axi_wdata   = s_axi_wvalid ? d : $urandom;
            s_axi_wstrb   = s_axi_wvalid ? s : 4'($urandom);
            err_write_i   = s_axi_wvalid ? ew : 1'($urandom);
            @(negedge clk);
            if (aw_ok && !w_ok) check("awready_low_after_aw", s_axi_awready, 0);
            if (w_ok && !aw_ok) check("wready_low_after_w", s_axi_wready, 0);
            if (s_axi_awvalid && s_axi_awready) aw_ok = 1;
            if (s_axi_wvalid && s_axi_wready) w_ok = 1;
            if (aw_ok && w_ok) hs_c = cyc;
            @(posedge clk); #1;
            k++;
        end
        check("write_capture_timeout", aw_ok && w_ok, 1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        err_awrite_i = 1'($urandom); err_write_i = 1'($urandom);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (s_axi_bvalid) begin bcyc = cyc; break; end
            @(posedge clk); #1;
            k++;
        end
        check("bvalid_timeout", bcyc >= 0, 1);
        if (bcyc >= 0) begin
            check("bvalid_latency", bcyc - hs_c, err ? 1 : wl + 1);
            check("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
            for (int i = 0; i < dly_b; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("bvalid_hold", s_axi_bvalid, 1);
                check("bresp_hold", s_axi_bresp, err ? 2'b10 : 2'b00);
            end
            @(posedge clk); #1;
            s_axi_bready = 1'b1;
            @(negedge clk);
            check("bvalid_at_bready", s_axi_bvalid, 1);
            @(posedge clk); #1;
            s_axi_bready = 1'b0;
        end
        check("wr_strobe_count", wr_log.size() - n_before, err ? 0 : 1);
        if (!err && wr_log.size() > n_before) begin
            ev = wr_log[n_before];
            check("wr_strobe_addr", ev.a, a);
            check("wr_strobe_data", ev.d, d);
            check("wr_strobe_strb", ev.s, s);
            check("wr_strobe_cycle", ev.c - hs_c, wl);
        end
        if (!err)
            for (int j = 0; j < 4; j++)
                if (s[j]) exp_mem[a[5:2]][j*8 +: 8] = d[j*8 +: 8];
    endtask

    // rl: cycles from AR handshake to the expected read strobe (1 uncontended).
    task automatic do_read(input logic [31:0] a, input bit e, input int dly_r, rl);
        int k = 0, hs_c = -1, rc = -1, n_before;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        n_before = rd_cyc.size();
        exp_d = e ? 32'd0 : exp_mem[a[5:2]];
        exp_r = e ? 2'b10 : 2'b00;
        s_axi_arvalid = 1'b1; s_axi_araddr = a; err_read_i = e;
        while (hs_c < 0 && k < 20) begin
            @(negedge clk);
            if (s_axi_arready) hs_c = cyc;
            @(posedge clk); #1;
            k++;
        end
        check("ar_timeout", hs_c >= 0, 1);
        s_axi_arvalid = 1'b0; s_axi_araddr = $urandom; err_read_i = 1'($urandom);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (s_axi_rvalid) begin rc = cyc; break; end
            @(posedge clk); #1;
            k++;
        end
        check("rvalid_timeout", rc >= 0, 1);
        if (rc >= 0) begin
            check("rvalid_latency", rc - hs_c, e ? 1 : rl + 2);
            check("rdata", s_axi_rdata, exp_d);
            check("rresp", s_axi_rresp, exp_r);
            for (int i = 0; i < dly_r; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("rvalid_hold", s_axi_rvalid, 1);
                check("rdata_hold", s_axi_rdata, exp_d);
                check("rresp_hold", s_axi_rresp, exp_r);
                check("arready_low_in_resp", s_axi_arready, 0);
            end
            @(posedge clk); #1;
            s_axi_rready = 1'b1;
            @(negedge clk);
            check("rvalid_at_rready", s_axi_rvalid, 1);
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
        end
        check("rd_strobe_count", rd_cyc.size() - n_before, e ? 0 : 1);
        if (!e && rd_cyc.size() > n_before) begin
            check("rd_strobe_cycle", rd_cyc[n_before] - hs_c, rl);
            check("rd_strobe_addr", rd_addr_log[n_before], a);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] ra, rd;
        logic [3:0]  rs;
        int          n;

        do_reset();

        // Simultaneous port requests from reset: write first, then read.
        fork
            do_write(32'h04, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 0, 1);
            do_read(32'h08, 0, 0, 2);
        join
        // Repeat tie: read wins this time.
        fork
            do_write(32'h0C, 32'h3333_4444, 4'hF, 0, 0, 0, 0, 0, 2);
            do_read(32'h04, 0, 0, 1);
        join

        // AW and W together.
        do_write(32'h10, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 0, 0, 1);
        // W three cycles before AW.
        do_write(32'h14, 32'h0BAD_F00D, 4'hF, 0, 0, 3, 0, 1, 1);
        // AW before W, partial strobes.
        do_write(32'h10, 32'h5A5A_5A5A, 4'h6, 0, 0, 0, 2, 0, 1);
        // Errored writes and read.
        do_write(32'h18, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, 0, 1);
        do_write(32'h1C, 32'hEEEE_EEEE, 4'hF, 0, 1, 1, 0, 2, 1);
        do_read(32'h10, 1, 2, 1);
        // Read of 0x20 with rready held off for 5 cycles.
        do_write(32'h20, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 1);
        do_read(32'h20, 0, 5, 1);
        do_read(32'h10, 0, 0, 1);

        // Reset while the write sits in W_ACCESS.
        n = wr_log.size();
        s_axi_awaddr = 32'h30; s_axi_awvalid = 1'b1; err_awrite_i = 1'b0;
        s_axi_wdata = 32'hCAFE_0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; err_write_i = 1'b0;
        @(negedge clk);
        check("rst_mid_aw_ready", s_axi_awready, 1);
        check("rst_mid_w_ready", s_axi_wready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; rst_i = 1'b1;
        @(negedge clk);
        check("rst_mid_no_wr", reg_wr_o, 0);
        check("rst_mid_bvalid", s_axi_bvalid, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_wready", s_axi_wready, 1);
        check("post_rst_arready", s_axi_arready, 1);
        check("post_rst_bvalid", s_axi_bvalid, 0);
        check("post_rst_reg_wr", reg_wr_o, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_strobe_count", wr_log.size() - n, 0);

        // Randomized stream against the memory model.
        for (int i = 0; i < 40; i++) begin
            ra = {26'd0, 4'($urandom), 2'b00};
            rd = $urandom;
            rs = 4'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_write(ra, rd, rs, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1);
            else
                do_read(ra, $urandom_range(0, 4) == 0, $urandom_range(0, 3), 1);
        end
        for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0, 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
